// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the read slave and the future write slave.
//   RESP_*     : AXI4-Lite response codes
//   rd_state_e : read-channel FSM states
//   clog2      : elaboration-time ceiling log2 helper
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rd_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_addr_check.sv
// Combinational address decode for an AXI4-Lite slave window.
//   addr_i   : incoming byte address
//   resp_o   : OKAY, SLVERR (misaligned) or DECERR (outside window)
//   offset_o : addr_i - BASE_ADDR, meaningful only when resp_o is OKAY
module axi_lite_addr_check
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter logic [64:0] RANGE_BYTES = 65'd4096
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [1:0]        resp_o,
    output logic [ADDR_W-1:0] offset_o
);

    localparam int unsigned     LSB_W = clog2(DATA_W / 8);
    // Window bounds carry one extra bit so BASE_ADDR+RANGE_BYTES never wraps.
    localparam logic [ADDR_W:0] LO    = {1'b0, BASE_ADDR[ADDR_W-1:0]};
    localparam logic [ADDR_W:0] HI    = LO + RANGE_BYTES[ADDR_W:0];

    logic [ADDR_W:0] addr_ext;

    always_comb begin
        addr_ext = {1'b0, addr_i};
        offset_o = addr_i - BASE_ADDR[ADDR_W-1:0];
        if (addr_ext < LO || addr_ext >= HI) begin
            resp_o = RESP_DECERR;
        end else if (addr_i[LSB_W-1:0] != '0) begin
            resp_o = RESP_SLVERR;
        end else begin
            resp_o = RESP_OKAY;
        end
    end

endmodule

// File: rtl/axi_lite_rd_slave_p.sv
// Parametrised AXI4-Lite read-channel slave in front of a fixed-latency backend.
//   clk, rst            : clock, asynchronous active-high reset
//   s_ar*               : read address channel (one outstanding transaction)
//   s_r*                : read data channel, all outputs registered
//   rd_en, rd_addr      : one-cycle backend read strobe and byte offset
//   rd_data             : backend data, valid RD_LAT cycles after rd_en
module axi_lite_rd_slave_p
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RD_LAT      = 1,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter logic [64:0] RANGE_BYTES = 65'd4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_arvalid,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_arready,
    output logic              s_rvalid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    input  logic              s_rready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data
);

    localparam logic [3:0] LAT = 4'(RD_LAT);

    rd_state_e         state_q,   state_d;
    logic [3:0]        cnt_q,     cnt_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;
    logic              rden_q,    rden_d;
    logic [ADDR_W-1:0] rdaddr_q,  rdaddr_d;

    logic [1:0]        chk_resp;
    logic [ADDR_W-1:0] chk_off;

    axi_lite_addr_check #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BASE_ADDR   (BASE_ADDR),
        .RANGE_BYTES (RANGE_BYTES)
    ) u_addr_check (
        .addr_i   (s_araddr),
        .resp_o   (chk_resp),
        .offset_o (chk_off)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rden_d    = 1'b0;
        rdaddr_d  = '0;
        case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (s_arvalid && arready_q) begin
                    arready_d = 1'b0;
                    if (chk_resp == RESP_OKAY) begin
                        rden_d   = 1'b1;
                        rdaddr_d = chk_off;
                        cnt_d    = LAT;
                        state_d  = WAIT;
                    end else begin
                        rdata_d  = '0;
                        rresp_d  = chk_resp;
                        rvalid_d = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            WAIT: begin
                arready_d = 1'b0;
                // Counter holds RD_LAT during the strobe cycle and reaches zero
                // exactly in the cycle the backend presents rd_data.
                if (cnt_q == 4'd0) begin
                    rdata_d  = rd_data;
                    rresp_d  = RESP_OKAY;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (s_rready) begin
                    rvalid_d  = 1'b0;
                    rdata_d   = '0;
                    rresp_d   = RESP_OKAY;
                    arready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
                rdata_d   = '0;
                rresp_d   = RESP_OKAY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rden_q    <= 1'b0;
            rdaddr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rden_q    <= rden_d;
            rdaddr_q  <= rdaddr_d;
        end
    end

    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign rd_en     = rden_q;
    assign rd_addr   = rdaddr_q;

endmodule

// File: tb/tb_axi_lite_rd_slave_p.sv
// Self-checking bench for axi_lite_rd_slave_p: a 32-bit/RD_LAT=2 instance and
// a 64-bit/RD_LAT=15 instance, each fed by a delay-queue backend model.
module tb_axi_lite_rd_slave_p;
    import axi_lite_pkg::*;

    localparam logic [63:0] B0 = 64'h1000;
    localparam logic [64:0] R0 = 65'h100;
    localparam int          L0 = 2;
    localparam logic [63:0] B1 = 64'h2000;
    localparam logic [64:0] R1 = 65'h1000;
    localparam int          L1 = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        arvalid0 = 1'b0, arready0, rvalid0, rready0 = 1'b0, rden0;
    logic [31:0] araddr0 = '0, rdata0, rdaddr0, rddata0 = '0;
    logic [1:0]  rresp0;

    logic        arvalid1 = 1'b0, arready1, rvalid1, rready1 = 1'b0, rden1;
    logic [31:0] araddr1 = '0, rdaddr1;
    logic [63:0] rdata1, rddata1 = '0;
    logic [1:0]  rresp1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lite_rd_slave_p #(
        .ADDR_W(32), .DATA_W(32), .RD_LAT(L0), .BASE_ADDR(B0), .RANGE_BYTES(R0)
    ) u0 (
        .clk(clk), .rst(rst),
        .s_arvalid(arvalid0), .s_araddr(araddr0), .s_arready(arready0),
        .s_rvalid(rvalid0), .s_rdata(rdata0), .s_rresp(rresp0), .s_rready(rready0),
        .rd_en(rden0), .rd_addr(rdaddr0), .rd_data(rddata0)
    );

    axi_lite_rd_slave_p #(
        .ADDR_W(32), .DATA_W(64), .RD_LAT(L1), .BASE_ADDR(B1), .RANGE_BYTES(R1)
    ) u1 (
        .clk(clk), .rst(rst),
        .s_arvalid(arvalid1), .s_araddr(araddr1), .s_arready(arready1),
        .s_rvalid(rvalid1), .s_rdata(rdata1), .s_rresp(rresp1), .s_rready(rready1),
        .rd_en(rden1), .rd_addr(rdaddr1), .rd_data(rddata1)
    );

    // Backend memory contents as a function of byte offset.
    function automatic logic [63:0] mem(input logic [63:0] off);
        if (off == 64'h8) return 64'h0000_0000_DEAD_BEEF;
        return {32'hC0DE_0000 ^ off[31:0], (off[31:0] * 32'h9E37_79B1) ^ 32'h1234_5678};
    endfunction

    // Reference decode straight from the window/alignment rules.
    function automatic logic [1:0] ref_resp(input longint unsigned a, input longint unsigned base,
                                            input longint unsigned range, input longint unsigned bytes);
        if (a < base || a >= base + range) return RESP_DECERR;
        if ((a % bytes) != 0) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Backend models: data requested in cycle c is presented during cycle c+RD_LAT,
    // random junk otherwise; reset discards anything in flight.
    initial begin : be0
        int cyc;
        longint unsigned dq[$];
        logic [63:0] vq[$];
        logic [63:0] v;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                dq.delete(); vq.delete();
                rddata0 = $urandom;
            end else begin
                if (rden0) begin
                    dq.push_back(longint'(cyc + L0));
                    vq.push_back(mem({32'h0, rdaddr0}));
                end
                if (dq.size() > 0 && dq[0] == longint'(cyc)) begin
                    void'(dq.pop_front());
                    v = vq.pop_front();
                    rddata0 = v[31:0];
                end else begin
                    rddata0 = $urandom;
                end
            end
        end
    end

    initial begin : be1
        int cyc;
        longint unsigned dq[$];
        logic [63:0] vq[$];
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                dq.delete(); vq.delete();
                rddata1 = {$urandom, $urandom};
            end else begin
                if (rden1) begin
                    dq.push_back(longint'(cyc + L1));
                    vq.push_back(mem({32'h0, rdaddr1}));
                end
                if (dq.size() > 0 && dq[0] == longint'(cyc)) begin
                    void'(dq.pop_front());
                    rddata1 = vq.pop_front();
                end else begin
                    rddata1 = {$urandom, $urandom};
                end
            end
        end
    end

    task automatic txn0(input logic [31:0] a, input logic [1:0] eresp, input int hold);
        int n, ren_cnt, ren_at;
        logic [31:0] radr, edata;
        logic [63:0] md;
        bit ok;
        md = mem({32'h0, a - B0[31:0]});
        edata = (eresp == RESP_OKAY) ? md[31:0] : 32'h0;
        arvalid0 = 1'b1; araddr0 = a; rready0 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (arready0) begin ok = 1'b1; break; end
            step();
        end
        chk("u0_ar_wait", 64'(ok), 64'd1);
        step();
        arvalid0 = 1'b0; araddr0 = $urandom;
        n = 1; ren_cnt = 0; ren_at = 0; radr = '0;
        while (!rvalid0 && n < 40) begin
            if (rden0) begin ren_cnt++; ren_at = n; radr = rdaddr0; end
            step();
            n++;
        end
        if (rden0) ren_cnt++;
        chk("u0_r_latency", 64'(n), (eresp == RESP_OKAY) ? 64'(2 + L0) : 64'd1);
        chk("u0_rd_en_count", 64'(ren_cnt), (eresp == RESP_OKAY) ? 64'd1 : 64'd0);
        if (eresp == RESP_OKAY) begin
            chk("u0_rd_en_cycle", 64'(ren_at), 64'd1);
            chk("u0_rd_addr", 64'(radr), 64'(a - B0[31:0]));
        end
        chk("u0_rdata", 64'(rdata0), 64'(edata));
        chk("u0_rresp", 64'(rresp0), 64'(eresp));
        for (int i = 0; i < hold; i++) begin
            arvalid0 = ~arvalid0;
            araddr0 = B0[31:0];
            step();
            chk("u0_hold_rvalid", 64'(rvalid0), 64'd1);
            chk("u0_hold_rdata", 64'(rdata0), 64'(edata));
            chk("u0_hold_rresp", 64'(rresp0), 64'(eresp));
            chk("u0_hold_arready", 64'(arready0), 64'd0);
        end
        arvalid0 = 1'b0;
        rready0 = 1'b1;
        step();
        rready0 = 1'b0;
        chk("u0_post_rvalid", 64'(rvalid0), 64'd0);
        chk("u0_post_rdata", 64'(rdata0), 64'd0);
        chk("u0_post_rresp", 64'(rresp0), 64'd0);
        chk("u0_post_arready", 64'(arready0), 64'd1);
    endtask

    task automatic txn1(input logic [31:0] a, input logic [1:0] eresp);
        int n, ren_cnt;
        logic [63:0] edata;
        bit ok;
        edata = (eresp == RESP_OKAY) ? mem({32'h0, a - B1[31:0]}) : 64'h0;
        arvalid1 = 1'b1; araddr1 = a; rready1 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (arready1) begin ok = 1'b1; break; end
            step();
        end
        chk("u1_ar_wait", 64'(ok), 64'd1);
        step();
        arvalid1 = 1'b0;
        n = 1; ren_cnt = 0;
        while (!rvalid1 && n < 40) begin
            if (rden1) ren_cnt++;
            step();
            n++;
        end
        chk("u1_r_latency", 64'(n), (eresp == RESP_OKAY) ? 64'(2 + L1) : 64'd1);
        chk("u1_rd_en_count", 64'(ren_cnt), (eresp == RESP_OKAY) ? 64'd1 : 64'd0);
        chk("u1_rdata", rdata1, edata);
        chk("u1_rresp", 64'(rresp1), 64'(eresp));
        step();
        rready1 = 1'b0;
        chk("u1_post_rvalid", 64'(rvalid1), 64'd0);
        chk("u1_post_arready", 64'(arready1), 64'd1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  resp;
        int          hold;
    } vec_t;

    vec_t tv0[9];
    vec_t tv1[6];

    initial begin : wdog
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] a;
        bit seen;

        tv0[0] = '{32'h0000_1008, RESP_OKAY,   5};
        tv0[1] = '{32'h0000_10FC, RESP_OKAY,   0};
        tv0[2] = '{32'h0000_1100, RESP_DECERR, 1};
        tv0[3] = '{32'h0000_0FFC, RESP_DECERR, 0};
        tv0[4] = '{32'h0000_1002, RESP_SLVERR, 2};
        tv0[5] = '{32'h0000_1102, RESP_DECERR, 0};
        tv0[6] = '{32'h0000_1000, RESP_OKAY,   3};
        tv0[7] = '{32'h0000_0000, RESP_DECERR, 0};
        tv0[8] = '{32'hFFFF_FFFC, RESP_DECERR, 0};

        tv1[0] = '{32'h0000_2004, RESP_SLVERR, 0};
        tv1[1] = '{32'h0000_2008, RESP_OKAY,   0};
        tv1[2] = '{32'h0000_2FF8, RESP_OKAY,   0};
        tv1[3] = '{32'h0000_3000, RESP_DECERR, 0};
        tv1[4] = '{32'h0000_1FF8, RESP_DECERR, 0};
        tv1[5] = '{32'h0000_200C, RESP_SLVERR, 0};

        // Reset values while rst is held.
        rst = 1'b1;
        step(); step(); step();
        chk("rst_u0_flags", 64'({arready0, rvalid0, rresp0, rden0}), 64'd0);
        chk("rst_u0_data", {rdata0, rdaddr0}, 64'd0);
        chk("rst_u1_flags", 64'({arready1, rvalid1, rresp1, rden1, rdaddr1}), 64'd0);
        chk("rst_u1_data", rdata1, 64'd0);
        rst = 1'b0;
        step();
        chk("rel_u0_arready", 64'(arready0), 64'd1);
        chk("rel_u0_rest", {28'h0, rvalid0, rresp0, rden0, rdata0}, 64'd0);
        chk("rel_u1_arready", 64'(arready1), 64'd1);
        chk("rel_u1_rest", 64'({rvalid1, rresp1, rden1, rdaddr1}), 64'd0);

        foreach (tv0[i]) txn0(tv0[i].addr, tv0[i].resp, tv0[i].hold);
        foreach (tv1[i]) txn1(tv1[i].addr, tv1[i].resp);

        // Reset one cycle after the rd_en strobe.
        arvalid0 = 1'b1; araddr0 = 32'h0000_1010;
        step();
        arvalid0 = 1'b0;
        chk("mw_rd_en", 64'(rden0), 64'd1);
        step();
        rst = 1'b1;
        #1;
        chk("mw_clear_flags", 64'({arready0, rvalid0, rresp0, rden0}), 64'd0);
        chk("mw_clear_data", {rdata0, rdaddr0}, 64'd0);
        step(); step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rvalid0) seen = 1'b1;
        end
        chk("mw_no_rvalid", 64'(seen), 64'd0);
        txn0(32'h0000_1010, RESP_OKAY, 0);

        // Randomised traffic against the reference decode.
        for (int i = 0; i < 24; i++) begin
            a = (i % 6 == 5) ? $urandom : (B0[31:0] - 32'h20 + 32'($urandom_range(0, 32'h140)));
            txn0(a, ref_resp(64'(a), B0, 64'(R0), 4), int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 6; i++) begin
            a = B1[31:0] - 32'h10 + 32'($urandom_range(0, 32'h1020));
            txn1(a, ref_resp(64'(a), B1, 64'(R1), 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
